// File: rtl/ec_pkg.sv
// Shared widths and FSM encoding for the fitness capture / best-tracking stage.
package ec_pkg;
  localparam int SELF_FIT_LENGTH   = 10;
  localparam int INDIVIDUAL_LENGTH = 22;
  localparam int IDX_WIDTH         = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;
endpackage

// File: rtl/fitness_rf.sv
// Fitness register file: one write port, one registered read port that
// returns zero for out-of-range slots and the pre-write value on a collision.
module fitness_rf
  import ec_pkg::*;
#(
  parameter int POP_SIZE = 50,
  localparam int AW = $clog2(POP_SIZE)
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_idx,
  input  logic [SELF_FIT_LENGTH-1:0] wr_data,
  input  logic                       rd_en,
  input  logic [IDX_WIDTH-1:0]       rd_idx,
  output logic [SELF_FIT_LENGTH-1:0] rd_data,
  output logic                       rd_valid
);

  logic [SELF_FIT_LENGTH-1:0] mem [POP_SIZE];
  logic                       rd_in_range;

  assign rd_in_range = rd_idx < IDX_WIDTH'(POP_SIZE);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < POP_SIZE; i++) mem[i] <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en) mem[wr_idx] <= wr_data;
      rd_valid <= rd_en;
      rd_data  <= rd_in_range ? mem[rd_idx[AW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/fitness_best_tracker.sv
// Captures scored individuals, tracks the generation's minimum-energy entry
// and pulses gen_done once POP_SIZE entries have been accepted.
module fitness_best_tracker
  import ec_pkg::*;
#(
  parameter int POP_SIZE  = 50,
  parameter int GEN_WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n,
  input  logic                         in_valid_i,
  input  logic [SELF_FIT_LENGTH-1:0]   total_energy_i,
  input  logic [INDIVIDUAL_LENGTH-1:0] individual_vec_i,
  input  logic [IDX_WIDTH-1:0]         ind_idx_i,
  input  logic                         rd_en_i,
  input  logic [IDX_WIDTH-1:0]         rd_idx_i,
  output logic [SELF_FIT_LENGTH-1:0]   rd_fitness_ff_o,
  output logic                         rd_valid_ff_o,
  output logic [SELF_FIT_LENGTH-1:0]   best_energy_ff_o,
  output logic [INDIVIDUAL_LENGTH-1:0] best_vec_ff_o,
  output logic [IDX_WIDTH-1:0]         best_idx_ff_o,
  output logic                         gen_done_ff_o,
  output logic [GEN_WIDTH-1:0]         gen_cnt_ff_o,
  output logic                         idx_err_ff_o
);

  localparam int AW = $clog2(POP_SIZE);

  state_t               state, state_nxt;
  logic [IDX_WIDTH-1:0] wr_cnt;
  logic                 accept, first, last, take_best;

  assign accept = in_valid_i && (ind_idx_i < IDX_WIDTH'(POP_SIZE));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // REPORT doubles as a start state so back-to-back generations lose no cycle.
  always_comb begin
    state_nxt = state;
    first     = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          first     = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (accept && (wr_cnt + IDX_WIDTH'(1) == IDX_WIDTH'(POP_SIZE))) begin
          last      = 1'b1;
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        if (accept) begin
          first     = 1'b1;
          state_nxt = COLLECT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    take_best = first ||
                (accept && (state == COLLECT) && (total_energy_i < best_energy_ff_o));
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt           <= '0;
      best_energy_ff_o <= '1;
      best_vec_ff_o    <= '0;
      best_idx_ff_o    <= '0;
      gen_done_ff_o    <= 1'b0;
      gen_cnt_ff_o     <= '0;
      idx_err_ff_o     <= 1'b0;
    end else begin
      if (first)                             wr_cnt <= IDX_WIDTH'(1);
      else if (accept && (state == COLLECT)) wr_cnt <= wr_cnt + IDX_WIDTH'(1);
      if (take_best) begin
        best_energy_ff_o <= total_energy_i;
        best_vec_ff_o    <= individual_vec_i;
        best_idx_ff_o    <= ind_idx_i;
      end
      gen_done_ff_o <= last;
      if (last) gen_cnt_ff_o <= gen_cnt_ff_o + GEN_WIDTH'(1);
      if (in_valid_i && !accept) idx_err_ff_o <= 1'b1;
    end
  end

  fitness_rf #(.POP_SIZE(POP_SIZE)) u_rf (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .wr_en    (accept),
    .wr_idx   (ind_idx_i[AW-1:0]),
    .wr_data  (total_energy_i),
    .rd_en    (rd_en_i),
    .rd_idx   (rd_idx_i),
    .rd_data  (rd_fitness_ff_o),
    .rd_valid (rd_valid_ff_o)
  );

endmodule
